multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_ctrl_pkg.sv | 62 ++++++
 rtl/alu_decoder.sv | 50 +++++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, mux selects,
// ALU/immediate codes, FSM states and the bundled control word.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_XOR  = 3'b110
  } aluop_t;

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_S = 3'b001,
    EXT_B = 3'b010,
    EXT_U = 3'b011,
    EXT_J = 3'b100
  } ext_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    aluop_t     aluop;
    ext_t       extend_func;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the current state and funct fields to an ALU operation; flags funct
// encodings this core does not implement. Purely combinational.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       func7_5,
  input  logic [2:0] func3,
  output aluop_t     aluop,
  output logic       illegal
);

  always_comb begin
    aluop   = ALU_ADD;
    illegal = 1'b0;
    case (state)
      S_EXEC_R: begin
        case ({func7_5, func3})
          4'b0000: aluop = ALU_ADD;
          4'b1000: aluop = ALU_SUB;
          4'b0111: aluop = ALU_AND;
          4'b0110: aluop = ALU_OR;
          4'b0010: aluop = ALU_SLT;
          4'b0011: aluop = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      S_EXEC_I: begin
        case (func3)
          3'b000:  aluop = ALU_ADD;
          3'b100:  aluop = ALU_XOR;
          3'b110:  aluop = ALU_OR;
          3'b111:  aluop = ALU_AND;
          3'b010:  aluop = ALU_SLT;
          3'b011:  aluop = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      S_BRANCH: begin
        aluop = ALU_SUB;
        case (func3)
          3'b000, 3'b001, 3'b100, 3'b101: illegal = 1'b0;
          default:                        illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore decode of state, with memory strobes gated
// by mem_ready and branch pcwrite from the compare flags; stalls in FETCH/MEM_* until mem_ready.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       ZERO,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] aluop,
  output logic [2:0] extend_func,
  output logic       illegal
);

  state_t state;
  aluop_t dec_aluop;
  logic   dec_illegal;
  logic   taken;
  ctrl_t  ctl;
  logic   unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  alu_decoder u_alu_decoder (
    .state   (state),
    .func7_5 (func7[5]),
    .func3   (func3),
    .aluop   (dec_aluop),
    .illegal (dec_illegal)
  );

  always_comb begin
    case (func3)
      3'b000:  taken = ZERO;
      3'b001:  taken = !ZERO;
      3'b100:  taken = neg;
      3'b101:  taken = !neg;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:     if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_R:         state <= S_EXEC_R;
            OP_I:         state <= S_EXEC_I;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BR:        state <= S_BRANCH;
            OP_JAL:       state <= S_JAL;
            OP_JALR:      state <= S_JALR;
            OP_LUI:       state <= S_LUI;
            default:      state <= S_TRAP;
          endcase
        end
        S_EXEC_R, S_EXEC_I: state <= dec_illegal ? S_TRAP : S_ALU_WB;
        S_MEM_ADDR:  state <= (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        S_MEM_WB, S_ALU_WB, S_LUI: state <= S_FETCH;
        S_BRANCH:    state <= dec_illegal ? S_TRAP : S_FETCH;
        // JALR redirects the PC, then JAL recomputes oldPC+4 for the link write.
        S_JALR:      state <= S_JAL;
        S_JAL:       state <= S_ALU_WB;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    ctl       = '0;
    ctl.aluop = dec_aluop;
    case (state)
      S_FETCH: begin
        ctl.alusrcb   = SRCB_FOUR;
        ctl.resultsrc = RES_ALU;
        ctl.irwrite   = mem_ready;
        ctl.pcwrite   = mem_ready;
      end
      S_DECODE: begin
        ctl.alusrca     = SRCA_OLDPC;
        ctl.alusrcb     = SRCB_IMM;
        ctl.extend_func = (op == OP_JAL) ? EXT_J : EXT_B;
      end
      S_EXEC_R: begin
        ctl.alusrca = SRCA_RD1;
        ctl.alusrcb = SRCB_RD2;
      end
      S_EXEC_I: begin
        ctl.alusrca     = SRCA_RD1;
        ctl.alusrcb     = SRCB_IMM;
        ctl.extend_func = EXT_I;
      end
      S_MEM_ADDR: begin
        ctl.alusrca     = SRCA_RD1;
        ctl.alusrcb     = SRCB_IMM;
        ctl.extend_func = (op == OP_SW) ? EXT_S : EXT_I;
      end
      S_MEM_READ: ctl.adrsrc = 1'b1;
      S_MEM_WB: begin
        ctl.resultsrc = RES_MDR;
        ctl.regwrite  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctl.adrsrc   = 1'b1;
        ctl.memwrite = mem_ready;
      end
      S_ALU_WB: begin
        ctl.resultsrc = RES_ALUOUT;
        ctl.regwrite  = 1'b1;
      end
      S_BRANCH: begin
        ctl.alusrca   = SRCA_RD1;
        ctl.alusrcb   = SRCB_RD2;
        ctl.resultsrc = RES_ALUOUT;
        ctl.pcwrite   = taken && !dec_illegal;
      end
      S_JAL: begin
        ctl.alusrca   = SRCA_OLDPC;
        ctl.alusrcb   = SRCB_FOUR;
        ctl.resultsrc = RES_ALUOUT;
        ctl.pcwrite   = 1'b1;
      end
      S_JALR: begin
        ctl.alusrca     = SRCA_RD1;
        ctl.alusrcb     = SRCB_IMM;
        ctl.extend_func = EXT_I;
        ctl.resultsrc   = RES_ALU;
        ctl.pcwrite     = 1'b1;
      end
      S_LUI: begin
        ctl.extend_func = EXT_U;
        ctl.resultsrc   = RES_IMM;
        ctl.regwrite    = 1'b1;
      end
      S_TRAP:  ctl.illegal = 1'b1;
      default: ;
    endcase
    // Outputs are quiet for the whole reset assertion, not just after the next edge.
    if (!rst) ctl = '0;
  end

  assign pcwrite     = ctl.pcwrite;
  assign adrsrc      = ctl.adrsrc;
  assign memwrite    = ctl.memwrite;
  assign irwrite     = ctl.irwrite;
  assign regwrite    = ctl.regwrite;
  assign alusrca     = ctl.alusrca;
  assign alusrcb     = ctl.alusrcb;
  assign resultsrc   = ctl.resultsrc;
  assign aluop       = ctl.aluop;
  assign extend_func = ctl.extend_func;
  assign illegal     = ctl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Random instruction stream checked cycle by cycle against expected control-word
// sequences built per instruction from the control rules.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       ZERO, neg, mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic [2:0] aluop, extend_func;

  typedef struct packed {
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic [2:0] aluop, extend_func;
    logic       illegal;
  } exp_t;

  exp_t  eq[$];
  bit    rq[$];
  logic [17:0] dut_vec;
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur;

  assign dut_vec = {pcwrite, adrsrc, memwrite, irwrite, regwrite,
                    alusrca, alusrcb, resultsrc, aluop, extend_func, illegal};

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .ZERO(ZERO), .neg(neg), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
    .aluop(aluop), .extend_func(extend_func), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit r_alu(input bit f75, input logic [2:0] f3, output logic [2:0] a);
    a = 3'd0;
    r_alu = 1'b1;
    case ({f75, f3})
      4'b0000: a = 3'b000;
      4'b1000: a = 3'b001;
      4'b0111: a = 3'b010;
      4'b0110: a = 3'b011;
      4'b0010: a = 3'b100;
      4'b0011: a = 3'b101;
      default: r_alu = 1'b0;
    endcase
  endfunction

  function automatic bit i_alu(input logic [2:0] f3, output logic [2:0] a);
    a = 3'd0;
    i_alu = 1'b1;
    case (f3)
      3'b000: a = 3'b000;
      3'b100: a = 3'b110;
      3'b110: a = 3'b011;
      3'b111: a = 3'b010;
      3'b010: a = 3'b100;
      3'b011: a = 3'b101;
      default: i_alu = 1'b0;
    endcase
  endfunction

  task automatic push(input exp_t e, input bit r);
    eq.push_back(e);
    rq.push_back(r);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle control words and mem_ready drive for one instruction.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input bit z, input bit n, input int wf, input int wm,
                       output bit trapped);
    exp_t c;
    logic [2:0] a;
    bit ok, tk;
    eq.delete();
    rq.delete();
    trapped = 1'b0;
    for (int i = 0; i <= wf; i++) begin
      c = '0; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      c.pcwrite = (i == wf); c.irwrite = (i == wf);
      push(c, i == wf);
    end
    c = '0; c.alusrca = 2'b01; c.alusrcb = 2'b01;
    c.extend_func = (o == 7'b1101111) ? 3'b100 : 3'b010;
    push(c, rb());
    case (o)
      7'b0110011: begin
        ok = r_alu(f7[5], f3, a);
        c = '0; c.alusrca = 2'b10; c.aluop = a; push(c, rb());
        trapped = !ok;
      end
      7'b0010011: begin
        ok = i_alu(f3, a);
        c = '0; c.alusrca = 2'b10; c.alusrcb = 2'b01; c.extend_func = 3'b000; c.aluop = a;
        push(c, rb());
        trapped = !ok;
      end
      7'b0000011, 7'b0100011: begin
        c = '0; c.alusrca = 2'b10; c.alusrcb = 2'b01;
        c.extend_func = (o == 7'b0100011) ? 3'b001 : 3'b000;
        push(c, rb());
        for (int i = 0; i <= wm; i++) begin
          c = '0; c.adrsrc = 1'b1;
          if (o == 7'b0100011) c.memwrite = (i == wm);
          push(c, i == wm);
        end
        if (o == 7'b0000011) begin
          c = '0; c.resultsrc = 2'b01; c.regwrite = 1'b1; push(c, rb());
        end
      end
      7'b1100011: begin
        ok = 1'b1;
        case (f3)
          3'b000: tk = z;
          3'b001: tk = !z;
          3'b100: tk = n;
          3'b101: tk = !n;
          default: begin tk = 1'b0; ok = 1'b0; end
        endcase
        c = '0; c.alusrca = 2'b10; c.aluop = 3'b001; c.pcwrite = tk; push(c, rb());
        trapped = !ok;
      end
      7'b1101111, 7'b1100111: begin
        if (o == 7'b1100111) begin
          c = '0; c.alusrca = 2'b10; c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.pcwrite = 1'b1;
          push(c, rb());
        end
        c = '0; c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcwrite = 1'b1; push(c, rb());
      end
      7'b0110111: begin
        c = '0; c.extend_func = 3'b011; c.resultsrc = 2'b11; c.regwrite = 1'b1; push(c, rb());
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      for (int i = 0; i < 12; i++) begin
        c = '0; c.illegal = 1'b1; push(c, rb());
      end
    end else if (o == 7'b0110011 || o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100111) begin
      c = '0; c.regwrite = 1'b1; push(c, rb());
    end
  endtask

  task automatic run(input int limit);
    for (int i = 0; i < eq.size() && i < limit; i++) begin
      mem_ready = rq[i];
      @(negedge clk);
      check($sformatf("%s step%0d", cur, i), 32'(dut_vec), 32'(eq[i]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_ready = rb();
    #2 check("reset_out", 32'(dut_vec), 32'd0);
    @(posedge clk);
    #1 check("reset_hold", 32'(dut_vec), 32'd0);
    rst = 1'b1;
  endtask

  task automatic instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input bit z, input bit n,
                       input int wf, input int wm);
    bit tr;
    cur = name;
    op = o; func3 = f3; func7 = f7; ZERO = z; neg = n;
    build(o, f3, f7, z, n, wf, wm, tr);
    run(1000);
    if (tr) do_reset();
  endtask

  initial begin
    bit tr;
    logic [6:0] o;
    int k;
    rst = 1'b0; op = '0; func3 = '0; func7 = '0; ZERO = 0; neg = 0; mem_ready = 0;
    #3 check("reset_t0", 32'(dut_vec), 32'd0);
    @(posedge clk); #1;
    do_reset();

    instr("add",   7'b0110011, 3'b000, 7'h00, 0, 0, 0, 0);
    instr("sub",   7'b0110011, 3'b000, 7'h20, 0, 0, 1, 0);
    instr("lw_w3", 7'b0000011, 3'b010, 7'h00, 0, 0, 0, 3);
    instr("beq_z", 7'b1100011, 3'b000, 7'h00, 1, 0, 0, 0);
    instr("bne_z", 7'b1100011, 3'b001, 7'h00, 1, 0, 0, 0);
    instr("blt_n", 7'b1100011, 3'b100, 7'h00, 0, 1, 0, 0);
    instr("jal",   7'b1101111, 3'b000, 7'h00, 0, 0, 0, 0);
    instr("lui",   7'b0110111, 3'b000, 7'h00, 0, 0, 2, 0);
    instr("op0",   7'b0000000, 3'b000, 7'h00, 0, 0, 0, 0);

    // sw stalled in its memory wait, reset pulsed with mem_ready high
    cur = "sw_abort";
    op = 7'b0100011; func3 = 3'b010; func7 = '0;
    build(op, func3, func7, 0, 0, 0, 6, tr);
    run(5);
    mem_ready = 1'b1;
    rst = 1'b0;
    #1 check("sw_abort_memwrite", 32'(memwrite), 32'd0);
    check("sw_abort_out", 32'(dut_vec), 32'd0);
    #1 rst = 1'b1;
    instr("add_after_abort", 7'b0110011, 3'b111, 7'h00, 0, 0, 0, 0);

    for (int it = 0; it < 150; it++) begin
      k = $urandom_range(0, 8);
      case (k)
        0: o = 7'b0110011;
        1: o = 7'b0010011;
        2: o = 7'b0000011;
        3: o = 7'b0100011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        6: o = 7'b1100111;
        7: o = 7'b0110111;
        default: begin
          o = 7'($urandom);
          while (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 || o == 7'b0100011 ||
                 o == 7'b1100011 || o == 7'b1101111 || o == 7'b1100111 || o == 7'b0110111)
            o = 7'($urandom);
        end
      endcase
      instr($sformatf("rnd%0d_op%02h", it, o), o, 3'($urandom), 7'($urandom),
            rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
